// File: rtl/bitstream_pkg.sv
// Shared state encoding and sizing helpers for the bitstream transmitter.
// ST_CHECK exists only when BITSTREAM_TX_CHECKSUM_EN is defined.
package bitstream_pkg;

    localparam int HDR_COUNT_WIDTH = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_PAYLOAD  = 3'd2,
`ifdef BITSTREAM_TX_CHECKSUM_EN
        ST_CHECK    = 3'd3,
`endif
        ST_DRAIN    = 3'd4,
        ST_WAIT_RDY = 3'd5
    } t_bitstream_tx_state;

    function automatic int BYTES_PER_WORD(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/bitstream_tx_axis_fifo2.sv
// Two-entry AXI-stream skid FIFO; the head is held stable until it is popped
// and reads as zero while empty so stale words never leak onto the bus.
module axis_fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_ready && (count_reg != 2'd0);
    assign do_push = push && (count_reg != 2'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_reg[0] <= '0;
            mem_reg[1] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign valid = (count_reg != 2'd0);
    assign head  = valid ? mem_reg[rd_ptr_reg] : '0;
    assign count = count_reg;

endmodule

// File: rtl/bitstream_tx.sv
// Byte-wide loader to configuration AXI-stream: header + payload packed LSB-first.
// Define BITSTREAM_TX_CHECKSUM_EN to require a trailing XOR checksum byte.
module bitstream_tx
    import bitstream_pkg::*;
#(
    parameter int BITSTREAM_DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [7:0]                      byte_in,
    input  logic                            byte_valid,
    output logic                            byte_ready,
    output logic                            cfg_bitstream_tvalid,
    output logic [BITSTREAM_DATA_WIDTH-1:0] cfg_bitstream_tdata,
    output logic                            cfg_bitstream_tlast,
    input  logic                            cfg_bitstream_tready,
    output logic                            cfg,
    input  logic                            cfg_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int W     = BITSTREAM_DATA_WIDTH;
    localparam int BPW   = BYTES_PER_WORD(W);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    t_bitstream_tx_state        state_reg;
    logic [IDX_W-1:0]           byte_idx_reg;
    logic [HDR_COUNT_WIDTH-1:0] words_left_reg;
    logic [BPW*8-1:0]           word_reg;
    logic [BPW*8-1:0]           word_next;
    logic [TO_W-1:0]            timeout_cnt_reg;
    logic                       cfg_reg;
    logic                       done_reg;
    logic                       err_reg;
`ifdef BITSTREAM_TX_CHECKSUM_EN
    logic [7:0]                 xor_reg;
`endif

    logic       byte_accept;
    logic       word_end;
    logic       last_word;
    logic       fifo_push;
    logic [W:0] fifo_push_data;
    logic [W:0] fifo_head;
    logic       fifo_valid;
    logic [1:0] fifo_count;
    logic       drain_done;

    // Each lane takes the incoming byte when it is the lane being filled.
    for (genvar gi = 0; gi < BPW; gi++) begin : g_byte_lane
        assign word_next[8*gi +: 8] = (byte_idx_reg == IDX_W'(gi)) ? byte_in
                                                                   : word_reg[8*gi +: 8];
    end

    always_comb begin
        byte_ready = 1'b0;
        case (state_reg)
            ST_HEADER:  byte_ready = 1'b1;
            ST_PAYLOAD: byte_ready = (fifo_count < 2'd2);
`ifdef BITSTREAM_TX_CHECKSUM_EN
            ST_CHECK:   byte_ready = 1'b1;
`endif
            default:    byte_ready = 1'b0;
        endcase
    end

    assign byte_accept    = byte_valid && byte_ready;
    assign word_end       = (byte_idx_reg == IDX_W'(BPW - 1));
    assign last_word      = (words_left_reg == HDR_COUNT_WIDTH'(1));
    assign fifo_push      = byte_accept && (state_reg == ST_PAYLOAD) && word_end;
    assign fifo_push_data = {last_word, word_next[W-1:0]};
    // Leave DRAIN in the same cycle the final beat handshakes.
    assign drain_done     = (fifo_count == 2'd0) ||
                            ((fifo_count == 2'd1) && cfg_bitstream_tready);

    axis_fifo2 #(
        .WIDTH(W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(fifo_push_data),
        .pop_ready(cfg_bitstream_tready),
        .valid    (fifo_valid),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            byte_idx_reg    <= '0;
            words_left_reg  <= '0;
            word_reg        <= '0;
            timeout_cnt_reg <= '0;
            cfg_reg         <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
`ifdef BITSTREAM_TX_CHECKSUM_EN
            xor_reg         <= 8'd0;
`endif
        end else begin
            cfg_reg  <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg       <= ST_HEADER;
                        cfg_reg         <= 1'b1;
                        err_reg         <= 1'b0;
                        byte_idx_reg    <= '0;
                        word_reg        <= '0;
                        timeout_cnt_reg <= '0;
`ifdef BITSTREAM_TX_CHECKSUM_EN
                        xor_reg         <= 8'd0;
`endif
                    end
                end
                ST_HEADER: begin
                    if (byte_accept) begin
                        words_left_reg <= HDR_COUNT_WIDTH'(byte_in) + HDR_COUNT_WIDTH'(1);
                        state_reg      <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_accept) begin
`ifdef BITSTREAM_TX_CHECKSUM_EN
                        xor_reg <= xor_reg ^ byte_in;
`endif
                        if (word_end) begin
                            byte_idx_reg   <= '0;
                            word_reg       <= '0;
                            words_left_reg <= words_left_reg - HDR_COUNT_WIDTH'(1);
                            if (last_word) begin
`ifdef BITSTREAM_TX_CHECKSUM_EN
                                state_reg <= ST_CHECK;
`else
                                state_reg <= ST_DRAIN;
`endif
                            end
                        end else begin
                            byte_idx_reg <= byte_idx_reg + IDX_W'(1);
                            word_reg     <= word_next;
                        end
                    end
                end
`ifdef BITSTREAM_TX_CHECKSUM_EN
                ST_CHECK: begin
                    if (byte_accept) begin
                        if (byte_in != xor_reg) begin
                            err_reg <= 1'b1;
                        end
                        state_reg <= ST_DRAIN;
                    end
                end
`endif
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_reg       <= ST_WAIT_RDY;
                        timeout_cnt_reg <= '0;
                    end
                end
                ST_WAIT_RDY: begin
                    if (cfg_ready) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= ~err_reg;
                    end else if (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_reg <= ST_IDLE;
                        err_reg   <= 1'b1;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cfg_bitstream_tvalid = fifo_valid;
    assign cfg_bitstream_tdata  = fifo_head[W-1:0];
    assign cfg_bitstream_tlast  = fifo_head[W];
    assign cfg                  = cfg_reg;
    assign busy                 = (state_reg != ST_IDLE);
    assign done                 = done_reg;
    assign err                  = err_reg;

endmodule
